// File: rtl/irq_source_arbiter.sv
// Fixed-priority interrupt source arbiter: edge/level sources, one request at a time to the core controller.
// Define IRQ_SYNC_EN to insert a 2-flop synchronizer on src_i (adds 2 cycles of latency).
module irq_source_arbiter #(
  parameter int unsigned NUM_SRC    = 16,
  parameter logic [31:0] CAUSE_BASE = 32'h1000_0010,
  localparam int unsigned IDW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] mask_i,
  input  logic [NUM_SRC-1:0] mode_i,
  input  logic               irq_taken_i,
  input  logic               irq_ret_i,
  output logic               irq_req_o,
  output logic [IDW-1:0]     irq_id_o,
  output logic [31:0]        irq_cause_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clr;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     sel_idx;
  logic               sel_found;
  logic               req_q;
  logic [31:0]        cause_q;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  // Two-stage synchronizer for asynchronous peripheral lines
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src_i;
`endif

  assign rise   = src_s & ~src_prev_q & mode_i;
  assign active = mask_i & ((mode_i & pend_q) | (~mode_i & src_s));

  // Lowest index wins; scan downward so the last hit is the lowest
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = REQ;
          id_d    = sel_idx;
        end
      end
      REQ: begin
        if (irq_taken_i) begin
          state_d  = SERVICE;
          clr[id_q] = 1'b1;
        end else if (!active[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_ret_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A same-cycle rising edge re-sets a bit being cleared by the take
    pend_d = ((pend_q & ~clr) | rise) & mode_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
      req_q      <= 1'b0;
      cause_q    <= CAUSE_BASE;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      pend_q     <= pend_d;
      src_prev_q <= src_s;
      req_q      <= (state_d == REQ);
      cause_q    <= CAUSE_BASE + 32'(id_d);
    end
  end

  assign irq_req_o   = req_q;
  assign irq_id_o    = id_q;
  assign irq_cause_o = cause_q;

endmodule

// File: tb/tb_irq_source_arbiter.sv
// Self-checking bench for irq_source_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_irq_source_arbiter;

  localparam int unsigned N    = 16;
  localparam int unsigned IDW  = 4;
  localparam logic [31:0] BASE = 32'h1000_0010;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   src, mask, mode;
  logic           taken, ret;
  logic           irq_req;
  logic [IDW-1:0] irq_id;
  logic [31:0]    irq_cause;

  int n_err    = 0;
  int n_checks = 0;

  // Reference model state
  logic [N-1:0] m_pend, m_prev, m_s1, m_s2;
  int           m_state;  // 0 idle, 1 requesting, 2 in service
  int           m_id;

  irq_source_arbiter #(.NUM_SRC(N), .CAUSE_BASE(BASE)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src_i      (src),
    .mask_i     (mask),
    .mode_i     (mode),
    .irq_taken_i(taken),
    .irq_ret_i  (ret),
    .irq_req_o  (irq_req),
    .irq_id_o   (irq_id),
    .irq_cause_o(irq_cause)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_prev  = '0;
    m_s1    = '0;
    m_s2    = '0;
    m_state = 0;
    m_id    = 0;
  endtask

  // One clock of the arbiter's rules, applied to the inputs present at the edge
  task automatic model_step();
    logic [N-1:0] s, act, rise, p;
    int sel;
    s   = (SYNC_LAT != 0) ? m_s2 : src;
    sel = -1;
    for (int n = 0; n < N; n++) begin
      rise[n] = s[n] && !m_prev[n] && mode[n];
      act[n]  = mask[n] && (mode[n] ? m_pend[n] : s[n]);
    end
    for (int n = 0; n < N; n++)
      if (act[n] && sel < 0) sel = n;
    p = m_pend;
    if (m_state == 0) begin
      if (sel >= 0) begin
        m_state = 1;
        m_id    = sel;
      end
    end else if (m_state == 1) begin
      if (taken) begin
        m_state   = 2;
        p[m_id]   = 1'b0;
      end else if (!act[m_id]) begin
        m_state = 0;
      end
    end else begin
      if (ret) m_state = 0;
    end
    m_pend = (p | rise) & mode;
    m_prev = s;
    m_s2   = m_s1;
    m_s1   = src;
  endtask

  task automatic compare_outputs();
    check_eq("req",   32'(irq_req),    32'(m_state == 1));
    check_eq("id",    32'(irq_id),     32'(m_id));
    check_eq("cause", irq_cause,       BASE + 32'(m_id));
    check_eq("pend",  32'(dut.pend_q), 32'(m_pend));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic pulse_taken();
    taken = 1'b1;
    cycle();
    taken = 1'b0;
  endtask

  task automatic pulse_ret();
    ret = 1'b1;
    cycle();
    ret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    src   = '0;
    mask  = '1;
    mode  = '1;
    taken = 1'b0;
    ret   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_req",   32'(irq_req), 32'd0);
    check_eq("rst_id",    32'(irq_id),  32'd0);
    check_eq("rst_cause", irq_cause,    BASE);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Single edge source 3
    src[3] = 1'b1;
    cycle();
    src[3] = 1'b0;
    repeat (1 + SYNC_LAT) cycle();
    check_eq("s1_req",   32'(irq_req), 32'd1);
    check_eq("s1_id",    32'(irq_id),  32'd3);
    check_eq("s1_cause", irq_cause,    32'h1000_0013);
    pulse_taken();
    check_eq("s1_taken_req",  32'(irq_req),        32'd0);
    check_eq("s1_taken_pend", 32'(dut.pend_q[3]),  32'd0);
    pulse_ret();
    cycle();
    check_eq("s1_idle_req", 32'(irq_req), 32'd0);

    // Priority: sources 5 and 2 together
    src[5] = 1'b1;
    src[2] = 1'b1;
    cycle();
    src = '0;
    repeat (1 + SYNC_LAT) cycle();
    check_eq("pri_first_id", 32'(irq_id), 32'd2);
    pulse_taken();
    pulse_ret();
    check_eq("pri_idle_req", 32'(irq_req), 32'd0);
    cycle();
    check_eq("pri_second_req", 32'(irq_req), 32'd1);
    check_eq("pri_second_id",  32'(irq_id),  32'd5);
    pulse_taken();
    pulse_ret();
    cycle();

    // Level source 7 withdraws before being taken
    mode[7] = 1'b0;
    src[7]  = 1'b1;
    cycle();
    src[7] = 1'b0;
    repeat (SYNC_LAT) cycle();
    check_eq("lvl_req", 32'(irq_req), 32'd1);
    check_eq("lvl_id",  32'(irq_id),  32'd7);
    cycle();
    check_eq("lvl_withdraw", 32'(irq_req), 32'd0);
    repeat (2) cycle();
    check_eq("lvl_stay_idle", 32'(irq_req), 32'd0);
    mode[7] = 1'b1;

    // New edge on source 4 in the same cycle it is taken
    src[4] = 1'b1;
    cycle();
    src[4] = 1'b0;
    repeat (1 + SYNC_LAT) cycle();
    check_eq("col_req", 32'(irq_req), 32'd1);
    src[4] = 1'b1;
    repeat (SYNC_LAT) cycle();
    pulse_taken();
    src[4] = 1'b0;
    check_eq("col_pend", 32'(dut.pend_q[4]), 32'd1);
    check_eq("col_svc_req", 32'(irq_req), 32'd0);
    pulse_ret();
    cycle();
    check_eq("col_again_req", 32'(irq_req), 32'd1);
    check_eq("col_again_id",  32'(irq_id),  32'd4);
    pulse_taken();
    pulse_ret();
    cycle();

    // Masked pending source, then unmask, then reset mid-service
    mask[1] = 1'b0;
    src[1]  = 1'b1;
    cycle();
    src[1] = 1'b0;
    repeat (3 + SYNC_LAT) cycle();
    check_eq("msk_noreq", 32'(irq_req),       32'd0);
    check_eq("msk_pend",  32'(dut.pend_q[1]), 32'd1);
    mask[1] = 1'b1;
    cycle();
    check_eq("msk_req", 32'(irq_req), 32'd1);
    check_eq("msk_id",  32'(irq_id),  32'd1);
    src[9] = 1'b1;
    pulse_taken();
    src[9] = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_req",   32'(irq_req),    32'd0);
    check_eq("mid_rst_id",    32'(irq_id),     32'd0);
    check_eq("mid_rst_cause", irq_cause,       BASE);
    check_eq("mid_rst_pend",  32'(dut.pend_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    check_eq("post_rst_idle", 32'(irq_req), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        mask = N'($urandom);
        mode = N'($urandom);
      end
      src   = N'($urandom & $urandom & $urandom);
      taken = ($urandom_range(0, 2) == 0);
      ret   = ($urandom_range(0, 3) == 0);
      cycle();
    end
    taken = 1'b0;
    ret   = 1'b0;
    src   = '0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_source_arbiter.md
Name: irq_source_arbiter

Overview:
- Collects NUM_SRC peripheral interrupt lines and presents one request at a time on irq_req_o to the core interrupt controller.
- Latches edge-type sources into a pending register and passes level-type sources through live.
- Selects the lowest-index active source by fixed priority and tracks it through request, service and return.
- Sits directly upstream of the interrupt controller: irq_req_o drives its request input; its irq_o (taken) and irq_ret_o feed back here.

Parameters:
- NUM_SRC, 16, number of interrupt source lines (2..32).
- CAUSE_BASE, 32'h1000_0010, cause value reported for source 0; source n reports CAUSE_BASE + n.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous reset, active-low.
- src_i  in  NUM_SRC  raw interrupt lines, one per source.
- mask_i  in  NUM_SRC  per-source enable; 1 = source may request.
- mode_i  in  NUM_SRC  per-source type; 1 = rising-edge, 0 = level-high.
- irq_taken_i  in  1  controller accepted the current request (its irq_o).
- irq_ret_i  in  1  controller finished the handler (its irq_ret_o).
- irq_req_o  out  1  request to the controller.
- irq_id_o  out  $clog2(NUM_SRC)  index of the selected or in-service source.
- irq_cause_o  out  32  CAUSE_BASE + irq_id_o, zero-extended.

Behaviour:
- Reset (already decided): one clock, clk_i; reset is asynchronous and active-low, rst_ni.
  - While rst_ni = 0: pending = 0, src_prev = 0, state = IDLE, irq_req_o = 0, irq_id_o = 0, irq_cause_o = CAUSE_BASE.
  - Asserting reset mid-operation abandons any request or service immediately, with no handshake.
- Edge detection:
  - src_prev registers src_i every cycle.
  - Rising edge of source n = src_i[n] & ~src_prev[n] & mode_i[n].
- Pending register, one bit per source:
  - Set on a rising edge.
  - Cleared when that source is taken: state REQ, irq_taken_i = 1, n = irq_id_o.
  - If set and clear hit the same bit in the same cycle, set wins, so the new edge stays pending.
  - Bits for mode_i = 0 sources remain 0.
- Active vector: active[n] = mask_i[n] & (mode_i[n] ? pending[n] : src_i[n]).
- Selection: lowest index n with active[n] = 1; pure fixed priority, no round-robin.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: irq_req_o = 0.
    - If any bit of active is set, latch the selected index into irq_id_o and go to REQ.
  - REQ: irq_req_o = 1; irq_id_o is held stable.
    - irq_taken_i = 1: go to SERVICE and clear the pending bit per the rule above.
    - Else, if active[irq_id_o] = 0 (level dropped or mask cleared): withdraw and go to IDLE; irq_req_o falls the next cycle.
    - A higher-priority source arriving while in REQ does not pre-empt.
  - SERVICE: irq_req_o = 0; irq_id_o is held.
    - irq_ret_i = 1: go to IDLE.
    - New edges keep accumulating in pending during SERVICE.
- irq_taken_i outside REQ and irq_ret_i outside SERVICE are ignored.
- Latency, with register k the first edge sampling src_i high:
  - Edge source: pending set after edge k, irq_req_o = 1 after edge k+1.
  - Level source: irq_req_o = 1 after edge k.
- Back-to-back: irq_ret_i in SERVICE → IDLE → next request one cycle later. No bubble beyond that single IDLE cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from src_i to irq_req_o.

Optional Feature:
- IRQ_SYNC_EN defined: src_i passes through a 2-flop synchronizer per bit, reset to 0, before edge detection and the active vector. All latencies above grow by 2 cycles.
- IRQ_SYNC_EN undefined: src_i is used directly and the caller guarantees it is synchronous to clk_i.

Test Plan:
- Single edge source: mode=1, mask=1 on source 3; pulse src_i[3] for 1 cycle.
  - Expect irq_req_o = 1 two cycles later with irq_id_o = 3 and irq_cause_o = 32'h1000_0013.
  - After irq_taken_i: irq_req_o = 0 and pending[3] = 0.
  - After irq_ret_i: IDLE.
- Priority: edges on sources 5 and 2 in the same cycle.
  - Expect id 2 served first.
  - After irq_ret_i, id 5 is requested one cycle after IDLE.
- Level withdraw: level source 7 high for 1 cycle, then low before irq_taken_i.
  - Expect irq_req_o to go 1 then back to 0, return to IDLE, and no service.
- Set/clear collision: source 4 pending in REQ; a new rising edge on src_i[4] in the same cycle as irq_taken_i.
  - Expect pending[4] = 1 after the edge.
  - Expect a second request for id 4 after irq_ret_i.
- Mask and reset: pending set on source 1 with mask_i[1] = 0 → no request; set the mask → request. Then drop rst_ni mid-SERVICE.
  - Expect immediate irq_req_o = 0, irq_id_o = 0, pending = 0, state IDLE.
- With IRQ_SYNC_EN: repeat the first scenario.
  - Expect irq_req_o four cycles after the src_i rise.
